// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencer for an iterative radix-2 shift-add multiplier (MUL opcode).
// It stalls the pipeline while the product is being computed. It then presents a
// one-cycle done pulse together with the registered result.
// Optional feature macro: MUL_HI_EN. When it is defined, the block adds the result_hi
// port and keeps the full 2*BIT_WIDTH signed product. When it is undefined, the
// datapath is only BIT_WIDTH wide, and result_lo is bit-identical in both builds.
module mul_seq_ctrl #(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_W     = $clog2(BIT_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [BIT_WIDTH-1:0] op_a,
  input  logic [BIT_WIDTH-1:0] op_b,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] result_lo
`ifdef MUL_HI_EN
  ,
  output logic [BIT_WIDTH-1:0] result_hi
`endif
);

`ifdef MUL_HI_EN
  localparam int AW = 2 * BIT_WIDTH;
`else
  localparam int AW = BIT_WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_WIDTH-1:0] mcand;
  logic [AW-1:0]        mplier;
  logic [AW-1:0]        acc;
  logic                 sign;

  logic [BIT_WIDTH-1:0] a_abs;
  logic [BIT_WIDTH-1:0] b_abs;
  logic [AW-1:0]        acc_next;
  logic [AW-1:0]        prod;

  // Operand magnitudes. The magnitude of MIN_INT wraps to 2^(BIT_WIDTH-1), which is correct when the value is read as unsigned.
  always_comb begin
    a_abs = op_a[BIT_WIDTH-1] ? (~op_a + BIT_WIDTH'(1)) : op_a;
    b_abs = op_b[BIT_WIDTH-1] ? (~op_b + BIT_WIDTH'(1)) : op_b;
  end

  // Accumulator update for this iteration, and the sign-corrected product after the final add.
  always_comb begin
    acc_next = mcand[0] ? (acc + mplier) : acc;
    prod     = sign ? (~acc_next + AW'(1)) : acc_next;
  end

  // Pipeline stall: hold on an accepted start and for every BUSY cycle, unless a flush is squashing the operation.
  always_comb begin
    stall = ((state == S_IDLE) && start && !flush) || ((state == S_BUSY) && !flush);
  end

  // Control FSM with the datapath and registered outputs.
  // The result register is loaded on the BUSY->DONE edge directly from the final-iteration sum, so done and result appear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
`ifdef MUL_HI_EN
      result_hi <= '0;
`endif
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      sign      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            state  <= S_BUSY;
            busy   <= 1'b1;
            mcand  <= a_abs;
            mplier <= AW'(b_abs);
            acc    <= '0;
            cnt    <= '0;
            sign   <= op_a[BIT_WIDTH-1] ^ op_b[BIT_WIDTH-1];
          end
        end
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand >> 1;
            mplier <= mplier << 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(BIT_WIDTH - 1)) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              result_lo <= prod[BIT_WIDTH-1:0];
`ifdef MUL_HI_EN
              result_hi <= prod[AW-1:BIT_WIDTH];
`endif
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl (BIT_WIDTH=32). Honours MUL_HI_EN the same way the design does.
module tb_mul_seq_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         flush;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
`ifdef MUL_HI_EN
  logic [W-1:0] result_hi;
`endif

  int n_checks;
  int n_fail;

  // Most recent product the model expects to be visible on the result ports.
  logic [W-1:0] exp_lo;
  logic [W-1:0] exp_hi;

  mul_seq_ctrl #(.BIT_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result_lo(result_lo)
`ifdef MUL_HI_EN
    ,
    .result_hi(result_hi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product: signed 64-bit multiply of the sign-extended operands.
  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    return 64'(p);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag);
    check({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
`ifdef MUL_HI_EN
    check({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
`endif
  endtask

  // Run one multiply and check the status outputs on every cycle against the expected timeline.
  // flush_at: the cycle index relative to the accepted start at which flush is pulsed (-1 means no flush).
  // repulse: drive random start and operand noise while the operation is in progress.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int flush_at, input bit repulse);
    logic [63:0] p;
    bit          exp_busy;
    bit          exp_done;
    p     = ref_prod(a, b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    check("stall_t0", 64'(stall), 64'(1));
    check("busy_t0", 64'(busy), 64'(0));
    step();
    for (int k = 1; k <= 34; k++) begin
      if (repulse && k <= 33 && (flush_at < 0 || k <= flush_at))
        start = 1'($urandom_range(0, 1));
      else
        start = 1'b0;
      op_a  = 32'($urandom);
      op_b  = 32'($urandom);
      flush = (k == flush_at);
      exp_busy = (k <= W) && (flush_at < 0 || k <= flush_at);
      exp_done = (k == W + 1) && !(flush_at >= 1 && flush_at <= W);
      @(negedge clk);
      check($sformatf("busy_t%0d", k), 64'(busy), 64'(exp_busy));
      check($sformatf("done_t%0d", k), 64'(done), 64'(exp_done));
      check($sformatf("stall_t%0d", k), 64'(stall), 64'(exp_busy && !flush));
      if (exp_done) begin
        exp_lo = p[31:0];
        exp_hi = p[63:32];
        check_results("res_done");
      end
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("busy_after", 64'(busy), 64'(0));
    check_results("res_held");
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa;
    n_checks = 0;
    n_fail   = 0;
    exp_lo   = '0;
    exp_hi   = '0;
    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // Hold reset for 3 cycles, then check the reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check_results("rst_res");
    step();
    rst = 1'b1;
    step();

    // Directed cases.
    run_mul(32'd3, 32'd5, -1, 1'b0);
    check("t1_lo15", 64'(result_lo), 64'(15));
    run_mul(32'hFFFF_FFFF, 32'd2, -1, 1'b0);
    run_mul(32'h8000_0000, 32'h8000_0000, -1, 1'b0);
    run_mul(32'd3, 32'd5, -1, 1'b0);
    run_mul(32'd7, 32'd9, 10, 1'b0);
    check("t4_keep15", 64'(result_lo), 64'(15));
    run_mul(32'd2, 32'd2, -1, 1'b1);
    run_mul(32'd5, 32'd11, W, 1'b0);
    run_mul(32'd13, 32'd3, W + 1, 1'b1);

    // When start and flush arrive together in IDLE, the flush wins.
    op_a  = 32'd9;
    op_b  = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("fw_stall", 64'(stall), 64'(0));
    step();
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("fw_busy", 64'(busy), 64'(0));
    check("fw_stall2", 64'(stall), 64'(0));
    step();

    // Assert reset in the middle of an operation.
    op_a  = 32'd6;
    op_b  = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    rst = 1'b0;
    #1;
    exp_lo = '0;
    exp_hi = '0;
    check("mr_busy", 64'(busy), 64'(0));
    check("mr_done", 64'(done), 64'(0));
    check("mr_stall", 64'(stall), 64'(0));
    check_results("mr_res");
    step();
    step();
    rst = 1'b1;
    step();
    run_mul(32'd6, 32'd7, -1, 1'b0);
    check("t6_lo42", 64'(result_lo), 64'(42));

    // Randomized operations.
    for (int i = 0; i < 16; i++) begin
      fa = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, W + 1)) : -1;
      run_mul(pick_operand(), pick_operand(), fa, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
